// File: rtl/altecc_pkg.sv
// Shared SECDED constants for the 64/72 write-path encoder and read-path decoder.
// Holds the check-bit masks, the injection mode encoding and small XOR helpers.
package altecc_pkg;

  localparam int ECC_DATA_W = 64;
  localparam int ECC_CHK_W  = 8;
  localparam int ECC_CW_W   = 72;

  typedef enum logic [1:0] {
    INJ_NONE   = 2'b00,
    INJ_SINGLE = 2'b01,
    INJ_DOUBLE = 2'b10,
    INJ_RSVD   = 2'b11
  } inj_mode_e;

  typedef logic [6:0][ECC_DATA_W-1:0] chk_mask_t;

  // Eight lane XORs for each of the seven Hamming bits, then eight lane
  // parities of the raw data (row 7) for the overall parity bit.
  typedef logic [ECC_DATA_W-1:0] chk_part_t;

  // Data bit j sits at the j-th Hamming position that is not a power of two.
  function automatic chk_mask_t gen_chk_mask();
    chk_mask_t m;
    int j;
    m = '0;
    j = 0;
    for (int p = 1; p < ECC_CW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int i = 0; i < 7; i++) begin
          if (((p >> i) & 1) != 0) m[i][j] = 1'b1;
        end
        j++;
      end
    end
    return m;
  endfunction

  localparam chk_mask_t CHK_MASK = gen_chk_mask();

  function automatic logic [ECC_CHK_W-1:0] chk_reduce(chk_part_t part);
    logic [ECC_CHK_W-1:0] c;
    for (int i = 0; i < 7; i++) c[i] = ^part[i*8 +: 8];
    c[7] = ^part[56 +: 8] ^ ^c[6:0];
    return c;
  endfunction

  // Positions past the codeword flip nothing.
  function automatic logic [ECC_CW_W-1:0] inj_onehot(logic [6:0] p);
    logic [ECC_CW_W-1:0] r;
    r = '0;
    if (p < 7'd72) r[p] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/altecc_chk_gen.sv
// Combinational SECDED check generator: data -> lane partials -> check byte.
// Ports: data in, part (per-lane XORs for pipelining), chk (final byte).
module altecc_chk_gen
  import altecc_pkg::*;
(
  input  logic [63:0] data,
  output logic [63:0] part,
  output logic [7:0]  chk
);

  always_comb begin
    part = '0;
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 7; i++) begin
        part[i*8+b] = ^(data[b*8 +: 8] & CHK_MASK[i][b*8 +: 8]);
      end
      part[56+b] = ^data[b*8 +: 8];
    end
  end

  assign chk = chk_reduce(part);

endmodule

// File: rtl/altecc_enc_pipe.sv
// Pipelined 64->72 SECDED encoder with valid/ready, error injection, word count.
// Ports: clock/reset, in_valid/in_ready/data, out_valid/out_ready/q, inj_*, enc_count.
module altecc_enc_pipe
  import altecc_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [71:0]      q,
  input  logic             inj_en,
  input  logic [1:0]       inj_mode,
  input  logic [6:0]       inj_pos0,
  input  logic [6:0]       inj_pos1,
  output logic             inj_armed,
  output logic             inj_done,
  output logic [CNT_W-1:0] enc_count
);

  logic        accept;
  logic        xfer;
  logic [63:0] part;
  logic [7:0]  chk;
  logic [71:0] mask;
  logic        fv;
  logic        ftag;
  logic [71:0] fq;
  inj_mode_e   arm_mode;
  logic [6:0]  arm_pos0;
  logic [6:0]  arm_pos1;

  altecc_chk_gen u_chk (
    .data (data),
    .part (part),
    .chk  (chk)
  );

  assign accept    = in_valid && in_ready;
  assign xfer      = fv && out_ready;
  assign out_valid = fv;
  assign q         = fv ? fq : '0;
  assign inj_done  = xfer && ftag;

  always_comb begin
    mask = inj_onehot(arm_pos0);
    if (arm_mode == INJ_DOUBLE) mask = mask | inj_onehot(arm_pos1);
    if (!inj_armed) mask = '0;
  end

  // A new arm wins over consumption, so an arm in an accept cycle
  // lands on the next word.
  always_ff @(posedge clock) begin
    if (reset) inj_armed <= 1'b0;
    else if (inj_en)
      inj_armed <= (inj_mode == INJ_SINGLE) || (inj_mode == INJ_DOUBLE);
    else if (accept) inj_armed <= 1'b0;
  end

  always_ff @(posedge clock) begin
    if (inj_en) begin
      arm_mode <= inj_mode_e'(inj_mode);
      arm_pos0 <= inj_pos0;
      arm_pos1 <= inj_pos1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) enc_count <= '0;
    else if (xfer) enc_count <= enc_count + 1'b1;
  end

  if (LATENCY == 1) begin : g_lat1
    logic part_unused;
    assign part_unused = ^part;
    assign in_ready = !fv || out_ready;

    always_ff @(posedge clock) begin
      if (reset) fv <= 1'b0;
      else if (in_ready) fv <= in_valid;
    end

    always_ff @(posedge clock) begin
      if (accept) begin
        fq   <= {chk, data} ^ mask;
        ftag <= inj_armed;
      end
    end
  end else begin : g_lat2
    logic        s1v;
    logic        s1tag;
    logic        s1adv;
    logic [63:0] s1d;
    logic [63:0] s1p;
    logic [71:0] s1m;
    logic        chk_unused;

    // Lane partials are registered; the final 8-input XORs run in stage 2.
    assign chk_unused = ^chk;
    assign s1adv    = s1v && (!fv || out_ready);
    assign in_ready = !s1v || s1adv;

    always_ff @(posedge clock) begin
      if (reset) begin
        s1v <= 1'b0;
        fv  <= 1'b0;
      end else begin
        if (in_ready) s1v <= in_valid;
        if (!fv || out_ready) fv <= s1v;
      end
    end

    always_ff @(posedge clock) begin
      if (accept) begin
        s1d   <= data;
        s1p   <= part;
        s1m   <= mask;
        s1tag <= inj_armed;
      end
      if (s1adv) begin
        fq   <= {chk_reduce(s1p), s1d} ^ s1m;
        ftag <= s1tag;
      end
    end
  end

endmodule

// File: tb/tb_altecc_enc_pipe.sv
// Self-checking bench for altecc_enc_pipe: scoreboard, stalls, injection, reset.
// Reference encoder/decoder are built from Hamming positions independently.
module tb_altecc_enc_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] data;
  logic        out_valid;
  logic        out_ready;
  logic [71:0] q;
  logic        inj_en;
  logic [1:0]  inj_mode;
  logic [6:0]  inj_pos0;
  logic [6:0]  inj_pos1;
  logic        inj_armed;
  logic        inj_done;
  logic [31:0] enc_count;

  altecc_enc_pipe #(.LATENCY(2), .CNT_W(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data      (data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .inj_en    (inj_en),
    .inj_mode  (inj_mode),
    .inj_pos0  (inj_pos0),
    .inj_pos1  (inj_pos1),
    .inj_armed (inj_armed),
    .inj_done  (inj_done),
    .enc_count (enc_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [71:0] cw;
    logic        tag;
  } exp_t;

  exp_t        sb[$];
  logic [71:0] got_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          xfers = 0;
  int          n_done = 0;
  logic        m_armed = 1'b0;
  logic [71:0] m_mask = '0;
  logic        rand_rdy = 1'b0;

  task automatic check(string tag, logic [71:0] got, logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] encode(logic [63:0] d);
    logic [6:0] s;
    int j;
    s = '0;
    j = 0;
    for (int p = 1; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[j]) s = s ^ 7'(p);
        j++;
      end
    end
    return {(^d) ^ (^s), s, d};
  endfunction

  // st: 0 clean, 1 corrected, 2 uncorrectable
  function automatic void decode(input logic [71:0] cw, output int st,
                                 output logic [63:0] d);
    logic [6:0] s;
    int j;
    s = '0;
    j = 0;
    d = cw[63:0];
    for (int p = 1; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cw[j]) s = s ^ 7'(p);
        j++;
      end
    end
    for (int i = 0; i < 7; i++) if (cw[64+i]) s = s ^ 7'(1 << i);
    if (^cw == 1'b0) st = (s == 0) ? 0 : 2;
    else begin
      st = 1;
      j = 0;
      for (int p = 1; p < 72; p++) begin
        if ((p & (p - 1)) != 0) begin
          if (p == int'(s)) d[j] = ~d[j];
          j++;
        end
      end
    end
  endfunction

  function automatic logic [71:0] mk_mask(logic [1:0] m, logic [6:0] p0,
                                          logic [6:0] p1);
    logic [71:0] r;
    r = '0;
    if (p0 < 7'd72) r[p0] = 1'b1;
    if (m == 2'b10 && p1 < 7'd72) r[p1] = 1'b1;
    return r;
  endfunction

  // Monitor / scoreboard, sampled at the falling edge.
  initial begin
    logic        prev_stall;
    logic [71:0] prev_q;
    exp_t        e;
    int          st;
    logic [63:0] dd;
    prev_stall = 1'b0;
    prev_q = '0;
    forever begin
      @(negedge clock);
      if (reset) prev_stall = 1'b0;
      else begin
        if (prev_stall) begin
          check("hold_v", out_valid, 1);
          check("hold_q", q, prev_q);
        end
        if (out_valid && out_ready) begin
          xfers++;
          got_q.push_back(q);
          if (inj_done) n_done++;
          if (sb.size() == 0) check("sb_empty", 0, 1);
          else begin
            e = sb.pop_front();
            check("q", q, e.cw);
            check("inj_done", inj_done, e.tag);
            if (!e.tag) begin
              decode(q, st, dd);
              check("dec_clean", st, 0);
            end
          end
        end else if (inj_done) check("done_spur", inj_done, 0);
        if (in_valid && in_ready) begin
          e.cw = encode(data);
          e.tag = m_armed;
          if (m_armed) e.cw = e.cw ^ m_mask;
          sb.push_back(e);
          m_armed = 1'b0;
        end
        if (inj_en) begin
          m_armed = (inj_mode == 2'b01) || (inj_mode == 2'b10);
          m_mask = mk_mask(inj_mode, inj_pos0, inj_pos1);
        end
        prev_stall = out_valid && !out_ready;
        prev_q = q;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: sim time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [63:0] d);
    in_valid = 1'b1;
    data = d;
    for (int k = 0; ; k++) begin
      @(negedge clock);
      if (in_ready) break;
      if (k > 300) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 500; k++) begin
      if (sb.size() == 0 && !out_valid) break;
      tick(1);
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic pulse_inj(input logic [1:0] m, input logic [6:0] p0,
                           input logic [6:0] p1);
    inj_en = 1'b1;
    inj_mode = m;
    inj_pos0 = p0;
    inj_pos1 = p1;
    tick(1);
    inj_en = 1'b0;
  endtask

  initial begin
    int          st;
    int          base;
    int          d0;
    logic [63:0] dd;
    logic [63:0] wa;
    logic [63:0] wb;
    reset = 1'b1;
    in_valid = 1'b0;
    data = '0;
    out_ready = 1'b1;
    inj_en = 1'b0;
    inj_mode = 2'b00;
    inj_pos0 = '0;
    inj_pos1 = '0;
    tick(3);
    reset = 1'b0;
    @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_q", q, 0);
    check("rst_armed", inj_armed, 0);
    check("rst_done", inj_done, 0);
    check("rst_count", enc_count, 0);
    tick(1);

    // Latency of two with no backpressure
    send(64'h0);
    @(negedge clock);
    check("lat1_v", out_valid, 0);
    tick(1);
    @(negedge clock);
    check("lat2_v", out_valid, 1);
    check("lat2_q", q, 72'h0);
    tick(1);
    @(negedge clock);
    check("cnt1", enc_count, 1);
    tick(1);

    send(64'h1);
    send(64'h2);
    drain();
    check("q_01", got_q[got_q.size()-2], 72'h83_0000000000000001);
    check("q_02", got_q[got_q.size()-1], 72'h85_0000000000000002);

    // Random stream with random backpressure
    base = xfers;
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) send({$urandom(), $urandom()});
    rand_rdy = 1'b0;
    tick(1);
    out_ready = 1'b1;
    drain();
    check("rand_xfers", xfers - base, 1000);
    check("rand_count", enc_count, xfers);

    // Single-bit injection
    d0 = n_done;
    pulse_inj(2'b01, 7'd5, 7'd0);
    check("armed_set", inj_armed, 1);
    send(64'h1);
    check("armed_clr", inj_armed, 0);
    drain();
    check("inj1_q", got_q[got_q.size()-1], 72'h83_0000000000000021);
    check("inj1_done", n_done - d0, 1);
    decode(got_q[got_q.size()-1], st, dd);
    check("inj1_st", st, 1);
    check("inj1_data", dd, 64'h1);

    // Double-bit injection
    pulse_inj(2'b10, 7'd0, 7'd71);
    send(64'hdead_beef_0123_4567);
    drain();
    decode(got_q[got_q.size()-1], st, dd);
    check("inj2_st", st, 2);

    // Out-of-range position is consumed but flips nothing
    pulse_inj(2'b01, 7'd100, 7'd0);
    check("oob_armed", inj_armed, 1);
    send(64'h5555_aaaa_0f0f_f0f0);
    check("oob_clr", inj_armed, 0);
    drain();
    check("oob_q", got_q[got_q.size()-1], encode(64'h5555_aaaa_0f0f_f0f0));

    // Reserved mode does not arm
    pulse_inj(2'b11, 7'd5, 7'd0);
    check("rsvd_armed", inj_armed, 0);

    // Arm in the same cycle as an acceptance hits the next word
    wa = 64'h0123_4567_89ab_cdef;
    wb = 64'hfedc_ba98_7654_3210;
    in_valid = 1'b1;
    data = wa;
    inj_en = 1'b1;
    inj_mode = 2'b01;
    inj_pos0 = 7'd2;
    tick(1);
    inj_en = 1'b0;
    send(wb);
    drain();
    check("same_a", got_q[got_q.size()-2], encode(wa));
    check("same_b", got_q[got_q.size()-1], encode(wb) ^ 72'h4);

    // Reset with two words in flight and injection armed
    out_ready = 1'b0;
    send(64'h1111);
    send(64'h2222);
    pulse_inj(2'b01, 7'd3, 7'd0);
    check("pre_rst_v", out_valid, 1);
    check("pre_rst_rdy", in_ready, 0);
    reset = 1'b1;
    sb.delete();
    m_armed = 1'b0;
    xfers = 0;
    tick(1);
    reset = 1'b0;
    check("mid_rst_v", out_valid, 0);
    check("mid_rst_armed", inj_armed, 0);
    check("mid_rst_cnt", enc_count, 0);
    check("mid_rst_rdy", in_ready, 1);
    out_ready = 1'b1;
    tick(3);
    check("post_rst_v", out_valid, 0);
    check("post_rst_cnt", enc_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/altecc_enc_pipe.md
Name: altecc_enc_pipe

Overview:
- Pipelined 64-to-72-bit SECDED (Hamming + overall parity) ECC encoder on the memory-controller write path.
- Sits ahead of DDR write data and produces check bits that are bit-compatible with the controller's 72-to-64 SECDED read-path decoder.
- Adds valid/ready flow control, a one-shot error-injection facility for decoder verification, and a running count of encoded words.

Parameters:
- LATENCY, 2, number of pipeline register stages from input acceptance to q; legal values 1 and 2.
- CNT_W, 32, width of enc_count.

Ports:
- clock  in  1  sole clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  data is valid this cycle.
- in_ready  out  1  encoder can accept data this cycle.
- data  in  64  raw write data.
- out_valid  out  1  q is valid.
- out_ready  in  1  downstream accepts q this cycle.
- q  out  72  codeword: q[63:0] = data (possibly injected), q[71:64] = check byte.
- inj_en  in  1  single-cycle pulse that arms error injection.
- inj_mode  in  2  00 none, 01 single-bit flip, 10 double-bit flip, 11 reserved (treated as 00).
- inj_pos0  in  7  first codeword bit index to flip (0..71).
- inj_pos1  in  7  second codeword bit index (used in mode 10 only).
- inj_armed  out  1  injection pending.
- inj_done  out  1  one-cycle pulse when the injected word is handed off at the output.
- enc_count  out  CNT_W  number of words transferred at the output since reset.

Behaviour:
- Code construction:
  - Hamming positions 1..71; powers of two (1,2,4,8,16,32,64) are check positions.
  - Data bit j maps to the j-th non-power-of-two position, ascending: bit 0 -> 3, bit 1 -> 5, bit 2 -> 6, bit 3 -> 7, bit 4 -> 9, and so on.
  - Check bit c[i] (i = 0..6) = XOR of all data bits whose position has bit i set.
  - q[64+i] = c[i].
  - q[71] = XOR of data[63:0] and c[6:0] (even overall parity).
- Pipeline:
  - LATENCY stages, each holding a valid bit plus its payload.
  - Stage 1 holds data, per-bit check partial XORs and the injection mask. The final stage holds q.
  - A stage loads when it is empty or its contents move on this cycle.
  - in_ready = !stage1_valid || stage1_advances. This is a combinational path from out_ready, and no skid buffer is used.
  - Latency: a word accepted in cycle N appears on q in cycle N+LATENCY when there is no backpressure.
  - q and out_valid hold stable while out_valid && !out_ready.
  - Full throughput of one word per cycle when out_ready = 1.
- Injection:
  - On inj_en, capture inj_mode/inj_pos0/inj_pos1 and set inj_armed = 1 if the mode is 01 or 10.
  - The next accepted word takes mask = onehot(pos0), OR'd with onehot(pos1) for mode 10. That word is tagged and inj_armed clears on the same edge.
  - Flips apply after check generation: the XOR on q is applied to the final codeword.
  - A position >= 72 contributes no bit, but the injection is still consumed.
  - pos0 == pos1 in mode 10 yields a single flip.
  - inj_en while already armed re-captures (last write wins).
  - inj_en in the same cycle as an acceptance applies to the following word, not the current one.
  - inj_done pulses in the cycle the tagged word transfers (out_valid && out_ready).
- enc_count increments on each output transfer and wraps modulo 2^CNT_W.
- Reset values: all stage valid bits 0, out_valid 0, in_ready 1 (stages empty), q 0, inj_armed 0, inj_done 0, enc_count 0.
  - Reset mid-stream discards all in-flight words and any pending injection, with no output transfer.
- Data payload registers need no reset. q is forced to 0 while !out_valid.

Decomposition:
- Package altecc_pkg:
  - ECC_DATA_W = 64, ECC_CHK_W = 8, ECC_CW_W = 72.
  - Function-generated constant array of seven 64-bit check masks (CHK_MASK[i]).
  - inj_mode enum.
  - The read-path decoder must import the same package.
- Sub-module altecc_chk_gen: purely combinational data[63:0] -> chk[7:0] using CHK_MASK. It is instantiated once, and the pipeline splits its XOR tree across stages when LATENCY = 2.

Test Plan:
- Reset, then data = 64'h0 -> q = 72'h00_0000000000000000 after 2 cycles; enc_count = 1.
- data = 64'h1 -> q = 72'h83_0000000000000001. data = 64'h2 -> q = 72'h85_0000000000000002.
- 1000 random words with out_ready randomly low 50% -> in-order output, no loss or duplication, q stable while stalled, each q passes through the team decoder with err_detected = 0; enc_count = 1000.
- inj_en with mode 01, pos0 = 5, then data = 64'h1 -> q = 72'h83_0000000000000021; inj_done pulses once; the decoder reports a corrected error and returns 64'h1.
- Mode 10 with pos0 = 0, pos1 = 71 -> the decoder flags err_fatal. Mode 01 with pos0 = 100 -> q is unmodified and inj_armed clears.
- Assert reset with 2 words in flight and injection armed -> next cycle out_valid = 0, inj_armed = 0, enc_count = 0, in_ready = 1.
